// File: rtl/nn_sequencer_if.sv
// Bus bundle between the NN instruction sequencer and the rest of the accelerator.
// master = sequencer side; slave = host, instruction memory and datapath side.
interface nn_sequencer_if #(
  parameter int unsigned INST_W = 32,
  parameter int unsigned IM_AW  = 8,
  parameter int unsigned XY_AW  = 10,
  parameter int unsigned W_AW   = 10,
  parameter int unsigned MASK_W = 2
);
  logic              start;
  logic [IM_AW-1:0]  start_addr;
  logic              abort;
  logic              busy;
  logic              done;
  logic              error;
  logic              inst_rd_en;
  logic [IM_AW-1:0]  inst_addr;
  logic [INST_W-1:0] inst_data;
  logic              buffer_empty;
  logic              mac_acc_update;
  logic              mac_acc_loopback;
  logic              serializer_update;
  logic              serializer_shift;
  logic [MASK_W-1:0] act_mask;
  logic [XY_AW-1:0]  xy_read_addr;
  logic [W_AW-1:0]   w_addr;
  logic              xy_write_enable;
  logic [XY_AW-1:0]  xy_write_addr;

  modport master (
    input  start, start_addr, abort, inst_data, buffer_empty,
    output busy, done, error, inst_rd_en, inst_addr,
    output mac_acc_update, mac_acc_loopback, serializer_update, serializer_shift,
    output act_mask, xy_read_addr, w_addr, xy_write_enable, xy_write_addr
  );

  modport slave (
    output start, start_addr, abort, inst_data, buffer_empty,
    input  busy, done, error, inst_rd_en, inst_addr,
    input  mac_acc_update, mac_acc_loopback, serializer_update, serializer_shift,
    input  act_mask, xy_read_addr, w_addr, xy_write_enable, xy_write_addr
  );
endinterface

// File: rtl/nn_sequencer.sv
// Instruction sequencer for the NN accelerator: MATMUL bursts, nested hardware loops,
// and ACCMOV write-back delayed to match the activation latency.
module nn_sequencer #(
  parameter int unsigned INST_W     = 32,
  parameter int unsigned IM_AW      = 8,
  parameter int unsigned XY_AW      = 10,
  parameter int unsigned W_AW       = 10,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned MASK_W     = 2,
  parameter int unsigned LOOP_DEPTH = 4,
  parameter int unsigned ACT_LAT    = 2
) (
  input logic            clk,
  input logic            reset,
  nn_sequencer_if.master bus
);

  localparam int unsigned SpW  = $clog2(LOOP_DEPTH + 1);
  localparam int unsigned IdxW = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;
  localparam int unsigned KW   = CNT_W + 1;

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StMac, StMove, StWaitbuf
  } state_e;

  typedef enum logic [2:0] {
    OpNop, OpMatmul, OpAccmov, OpJump, OpLoop, OpEndloop, OpWaitbuf, OpHalt
  } op_e;

  state_e            state_q, state_d;
  logic [IM_AW-1:0]  pc_q, pc_d;
  logic              error_q, error_d;
  logic [SpW-1:0]    sp_q, sp_d;
  logic [IM_AW-1:0]  stk_pc_q [LOOP_DEPTH];
  logic [IM_AW-1:0]  stk_pc_d [LOOP_DEPTH];
  logic [CNT_W-1:0]  stk_cnt_q [LOOP_DEPTH];
  logic [CNT_W-1:0]  stk_cnt_d [LOOP_DEPTH];
  logic [XY_AW-1:0]  x_q, x_d;
  logic [W_AW-1:0]   wb_q, wb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XY_AW-1:0]  y_q, y_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [KW-1:0]     k_q, k_d;
  logic [MASK_W-1:0] mask_q, mask_d;

  logic              rd_en, done, mac_up, mac_lb, ser_up, shift, flush;
  logic              wr_en;
  logic [XY_AW-1:0]  wr_addr, shift_addr;
  logic [IM_AW-1:0]  pc_inc;
  logic [IdxW-1:0]   top_idx, push_idx;
  logic [KW-1:0]     move_end;

  op_e               op;
  logic [XY_AW-1:0]  f_xy;
  logic [W_AW-1:0]   f_w;
  logic [CNT_W-1:0]  f_cnt, f_len, f_lcnt;
  logic [MASK_W-1:0] f_mask;
  logic [IM_AW-1:0]  f_target;

  // Field layout is LSB-first; which slice applies depends on the opcode.
  assign op       = op_e'(bus.inst_data[INST_W-1 -: 3]);
  assign f_xy     = bus.inst_data[XY_AW-1:0];
  assign f_w      = bus.inst_data[XY_AW +: W_AW];
  assign f_cnt    = bus.inst_data[XY_AW+W_AW +: CNT_W];
  assign f_len    = bus.inst_data[XY_AW +: CNT_W];
  assign f_mask   = bus.inst_data[XY_AW+CNT_W +: MASK_W];
  assign f_target = bus.inst_data[IM_AW-1:0];
  assign f_lcnt   = bus.inst_data[CNT_W-1:0];

  assign pc_inc     = pc_q + IM_AW'(1);
  assign top_idx    = IdxW'(sp_q - SpW'(1));
  assign push_idx   = IdxW'(sp_q);
  assign move_end   = {1'b0, len_q} + KW'(ACT_LAT);
  assign shift_addr = y_q + XY_AW'(k_q);
  assign flush      = bus.abort && (state_q != StIdle);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    error_d   = error_q;
    sp_d      = sp_q;
    stk_pc_d  = stk_pc_q;
    stk_cnt_d = stk_cnt_q;
    x_d       = x_q;
    wb_d      = wb_q;
    cnt_d     = cnt_q;
    y_d       = y_q;
    len_d     = len_q;
    k_d       = k_q;
    mask_d    = mask_q;
    rd_en     = 1'b0;
    done      = 1'b0;
    mac_up    = 1'b0;
    mac_lb    = 1'b0;
    ser_up    = 1'b0;
    shift     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          pc_d    = bus.start_addr;
          error_d = 1'b0;
          sp_d    = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        rd_en   = 1'b1;
        state_d = StDecode;
      end
      StDecode: begin
        state_d = StFetch;
        unique case (op)
          OpNop:  pc_d = pc_inc;
          OpJump: pc_d = f_target;
          OpMatmul: begin
            x_d     = f_xy;
            wb_d    = f_w;
            cnt_d   = f_cnt;
            k_d     = '0;
            state_d = StMac;
          end
          OpAccmov: begin
            ser_up  = 1'b1;
            mask_d  = f_mask;
            y_d     = f_xy;
            len_d   = f_len;
            k_d     = '0;
            state_d = StMove;
          end
          OpLoop: begin
            if (sp_q == SpW'(LOOP_DEPTH)) begin
              error_d = 1'b1;
              sp_d    = '0;
              state_d = StIdle;
            end else begin
              stk_pc_d[push_idx]  = pc_inc;
              stk_cnt_d[push_idx] = f_lcnt;
              sp_d                = sp_q + SpW'(1);
              pc_d                = pc_inc;
            end
          end
          OpEndloop: begin
            if (sp_q == '0) begin
              error_d = 1'b1;
              state_d = StIdle;
            end else if (stk_cnt_q[top_idx] == '0) begin
              sp_d = sp_q - SpW'(1);
              pc_d = pc_inc;
            end else begin
              stk_cnt_d[top_idx] = stk_cnt_q[top_idx] - CNT_W'(1);
              pc_d               = stk_pc_q[top_idx];
            end
          end
          OpWaitbuf: state_d = StWaitbuf;
          OpHalt: begin
            done    = 1'b1;
            sp_d    = '0;
            state_d = StIdle;
          end
          default: state_d = StIdle;
        endcase
      end
      StMac: begin
        mac_up = 1'b1;
        mac_lb = (k_q != '0);
        k_d    = k_q + KW'(1);
        if (k_q == {1'b0, cnt_q}) begin
          pc_d    = pc_inc;
          state_d = StFetch;
        end
      end
      StMove: begin
        // Shifts stop after length+1 beats; the state lingers until the delayed writes drain.
        shift = (k_q <= {1'b0, len_q});
        k_d   = k_q + KW'(1);
        if (k_q == move_end) begin
          pc_d    = pc_inc;
          state_d = StFetch;
        end
      end
      StWaitbuf: begin
        if (bus.buffer_empty) begin
          pc_d    = pc_inc;
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush) begin
      state_d = StIdle;
      sp_d    = '0;
      error_d = error_q;
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      error_q <= 1'b0;
      sp_q    <= '0;
      x_q     <= '0;
      wb_q    <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      len_q   <= '0;
      k_q     <= '0;
      mask_q  <= '0;
      for (int unsigned i = 0; i < LOOP_DEPTH; i++) begin
        stk_pc_q[i]  <= '0;
        stk_cnt_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      error_q   <= error_d;
      sp_q      <= sp_d;
      x_q       <= x_d;
      wb_q      <= wb_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
      len_q     <= len_d;
      k_q       <= k_d;
      mask_q    <= mask_d;
      stk_pc_q  <= stk_pc_d;
      stk_cnt_q <= stk_cnt_d;
    end
  end

  // Write strobe/address trail the shift by ACT_LAT cycles; abort empties the pipe.
  if (ACT_LAT == 0) begin : g_nopipe
    assign wr_en   = shift;
    assign wr_addr = shift_addr;
  end else begin : g_pipe
    logic [ACT_LAT-1:0] en_q;
    logic [XY_AW-1:0]   addr_q [ACT_LAT];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        en_q <= '0;
        for (int unsigned i = 0; i < ACT_LAT; i++) addr_q[i] <= '0;
      end else if (flush) begin
        en_q <= '0;
      end else begin
        en_q[0]   <= shift;
        addr_q[0] <= shift_addr;
        for (int unsigned i = 1; i < ACT_LAT; i++) begin
          en_q[i]   <= en_q[i-1];
          addr_q[i] <= addr_q[i-1];
        end
      end
    end

    assign wr_en   = en_q[ACT_LAT-1];
    assign wr_addr = addr_q[ACT_LAT-1];
  end

  assign bus.busy              = (state_q != StIdle);
  assign bus.done              = done;
  assign bus.error             = error_q;
  assign bus.inst_rd_en        = rd_en;
  assign bus.inst_addr         = pc_q;
  assign bus.mac_acc_update    = mac_up;
  assign bus.mac_acc_loopback  = mac_lb;
  assign bus.serializer_update = ser_up;
  assign bus.serializer_shift  = shift;
  assign bus.act_mask          = mask_q;
  assign bus.xy_read_addr      = (state_q == StMac) ? x_q + XY_AW'(k_q) : '0;
  assign bus.w_addr            = (state_q == StMac) ? wb_q + W_AW'(k_q) : '0;
  assign bus.xy_write_enable   = wr_en;
  assign bus.xy_write_addr     = wr_en ? wr_addr : '0;

endmodule

// File: doc/nn_sequencer.md
Name: nn_sequencer

Overview:
Parametrised instruction sequencer for the NN accelerator; successor to the single-level fixed-width controller.
- Fetches from a synchronous instruction memory and drives MAC, serializer, activation and XY/W memory addressing.
- Adds multi-cycle MATMUL bursts, a nested hardware loop stack, and a pipelined ACCMOV write-back with configurable activation latency.
- Adds start/busy/done/abort control with a sticky error flag.

Parameters:
INST_W, 32, instruction width; opcode is [INST_W-1:INST_W-3]
IM_AW, 8, instruction memory address width
XY_AW, 10, XY memory address width
W_AW, 10, weight memory address width
CNT_W, 8, burst/loop count field width
MASK_W, 2, activation mask width
LOOP_DEPTH, 4, loop stack entries
ACT_LAT, 2, cycles from serializer_shift to valid act data (0..7)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  begin execution at start_addr (honoured in IDLE only)
start_addr  in  IM_AW  first instruction address
abort  in  1  synchronous abort to IDLE
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse on HALT
error  out  1  sticky loop-stack overflow/underflow; cleared by start
inst_rd_en  out  1  instruction read strobe
inst_addr  out  IM_AW  instruction read address
inst_data  in  INST_W  read data, valid 1 cycle after inst_rd_en
buffer_empty  in  1  input buffer empty
mac_acc_update  out  1  MAC accumulate enable
mac_acc_loopback  out  1  accumulate onto previous sum
serializer_update  out  1  load serializer from MAC accumulators
serializer_shift  out  1  shift serializer one lane
act_mask  out  MASK_W  activation select, held between ACCMOVs
xy_read_addr  out  XY_AW  X operand address
w_addr  out  W_AW  weight address
xy_write_enable  out  1  Y write strobe
xy_write_addr  out  XY_AW  Y write address

Behaviour:
- Reset: all outputs 0, state IDLE, pc 0, stack empty, error 0.
- Fields are packed LSB-first:
  - MATMUL(1): x_addr, w_addr, count.
  - ACCMOV(2): y_addr, length, mask.
  - JUMP(3): target.
  - LOOP(4): count.
  - NOP(0), ENDLOOP(5), WAITBUF(6), HALT(7): no fields.
- States: IDLE, FETCH, DECODE, MAC, MOVE, WAITBUF.
- IDLE: on start, pc<=start_addr, error<=0, go FETCH.
- FETCH: inst_rd_en=1, inst_addr=pc; go DECODE.
- DECODE: inst_data is valid this cycle.
  - NOP: pc+1, go FETCH.
  - JUMP: pc=target, go FETCH.
  - MATMUL: latch fields; go MAC.
  - ACCMOV: serializer_update=1; act_mask<=mask; latch y_addr/length; go MOVE.
  - LOOP: push {pc+1, count}; pc+1; go FETCH. If the stack is full: error=1, go IDLE, no done.
  - ENDLOOP:
    - top count==0: pop, pc+1.
    - top count!=0: decrement top, pc=top.body.
    - Empty stack: error=1, go IDLE.
    - The loop body therefore runs count+1 times.
  - WAITBUF: go WAITBUF.
  - HALT: done=1 for that cycle, go IDLE, stack cleared.
- MAC: count+1 cycles, k=0..count.
  - mac_acc_update=1, mac_acc_loopback=(k!=0).
  - xy_read_addr=x_addr+k, w_addr=w_addr+k, both modulo 2^width.
  - After k=count: pc+1, go FETCH.
- MOVE: serializer_shift=1 for length+1 cycles, k=0..length.
  - xy_write_enable/xy_write_addr(y_addr+k) are the shift strobe/index delayed exactly ACT_LAT cycles through a shift-register pipeline.
  - Exit to FETCH (pc+1) only after the last delayed write has issued, i.e. length+1+ACT_LAT cycles in MOVE.
- WAITBUF: stay while buffer_empty==0; then pc+1, go FETCH.
- pc increments wrap modulo 2^IM_AW.
- Strobes (mac_*, serializer_*, xy_write_enable, inst_rd_en) are 0 in every state not listed as asserting them.
- abort (any state except IDLE): next cycle IDLE, stack cleared, MOVE pipeline flushed (no further writes), no done; error unchanged.
- start while busy: ignored.
- Nested loops: the inner ENDLOOP acts on the top entry only. Exactly LOOP_DEPTH nested LOOPs are legal; LOOP_DEPTH+1 sets error.

Test Plan:
- Program MATMUL(x=5,w=1020,count=3), HALT; start_addr=0 -> FETCH/DECODE, then 4 MAC cycles with xy_read_addr 5,6,7,8, w_addr 1020,1021,1022,1023, loopback 0,1,1,1; done pulse 1 cycle; busy falls the same cycle.
- ACCMOV(y=1022,length=3,mask=2), ACT_LAT=2 -> serializer_update 1 cycle; serializer_shift 4 cycles; xy_write_enable 4 cycles starting 2 cycles after first shift, addresses 1022,1023,0,1; act_mask=2 persists after.
- LOOP(1){LOOP(2){NOP}ENDLOOP}ENDLOOP, HALT -> inner NOP executes 6 times; done asserted; error=0.
- Five nested LOOPs with LOOP_DEPTH=4 -> error=1 at the 5th DECODE, busy=0, no done; a new start clears error. ENDLOOP with empty stack -> error=1.
- WAITBUF with buffer_empty=0 for 7 cycles then 1 -> no fetch during the wait; next inst_rd_en the cycle after buffer_empty rises.
- abort mid-MOVE after 2 shifts; reset asserted mid-MAC -> after abort no further xy_write_enable, IDLE, done=0; after reset all outputs 0 immediately (async).
